// File: rtl/naneye_link_sequencer_pkg.sv
// Shared state encoding and helpers for the NanEye link sequencer.
package naneye_link_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SYNC  = 3'd1,
    ST_CONFIG     = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_STREAM     = 3'd4,
    ST_RESYNC     = 3'd5,
    ST_FAIL       = 3'd6
  } state_e;

  // Decoder is powered in every state that is actively working on the link.
  function automatic logic dec_enabled(input state_e s);
    return (s == ST_WAIT_SYNC) || (s == ST_CONFIG) || (s == ST_WAIT_FRAME) ||
           (s == ST_STREAM) || (s == ST_RESYNC);
  endfunction

endpackage

// File: rtl/naneye_link_sequencer_timer.sv
// Free-running state timer with synchronous clear and a terminal-count flag.
module naneye_link_sequencer_timer #(
  parameter int unsigned TMR_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [TMR_W-1:0] limit,
  output logic             hit_c
);

  logic [TMR_W-1:0] count;

  // Count cycles since the last clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + TMR_W'(1);
    end
  end

  // Terminal count: the transition happens on the edge that ends this cycle.
  assign hit_c = (count == (limit - TMR_W'(1)));

endmodule

// File: rtl/naneye_link_sequencer.sv
// Link bring-up and supervision controller for the NanEye receive path.
module naneye_link_sequencer
  import naneye_link_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT  = 200000,
  parameter int unsigned FRAME_TIMEOUT = 4000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned RSYNC_LEN     = 4,
  parameter int unsigned TMR_W         = 24,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic               SCLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic               DEC_SYNC_START,
  input  logic               DEC_CONFIG_EN,
  input  logic               DEC_FRAME_START,
  input  logic               DEC_ERROR,
  input  logic               DES_RSYNC,
  input  logic               CFG_DONE,
  output logic               DEC_ENABLE,
  output logic               DEC_CONFIG_DONE,
  output logic               DEC_RSYNC,
  output logic               CFG_START,
  output logic               LINK_UP,
  output logic               LINK_FAIL,
  output logic               TIMEOUT_EV,
  output logic [FCNT_W-1:0]  FRAME_CNT,
  output logic [7:0]         ERR_CNT,
  output logic [STATE_W-1:0] STATE
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e             state;
  state_e             next_state;
  logic               timeout_fire;
  logic               tmr_clr;
  logic               tmr_hit_c;
  logic [TMR_W-1:0]   tmr_limit;
  logic [RETRY_W-1:0] retry;
  logic               start_ok;
  logic               resync_entry;
  logic               frame_inc;
  logic               nxt_dec_enable;
  logic               nxt_cfg_done;
  logic               nxt_rsync;
  logic               nxt_cfg_start;
  logic               nxt_link_up;
  logic               nxt_link_fail;

  // Timeout limit depends on which phase is being supervised.
  always_comb begin
    tmr_limit = TMR_W'(SYNC_TIMEOUT);
    if (state == ST_STREAM) begin
      tmr_limit = TMR_W'(FRAME_TIMEOUT);
    end else if (state == ST_RESYNC) begin
      tmr_limit = TMR_W'(RSYNC_LEN);
    end
  end

  // Restart the timer on any state change and on every accepted frame while streaming.
  assign tmr_clr = (next_state != state) || (state == ST_IDLE) || (state == ST_FAIL) ||
                   ((state == ST_STREAM) && DEC_FRAME_START);

  naneye_link_sequencer_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk   (SCLOCK),
    .rst_n (RESET),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .hit_c (tmr_hit_c)
  );

  // State register.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: abort beats error/timeout, which beat forward progress.
  always_comb begin
    next_state   = state;
    timeout_fire = 1'b0;
    if (ABORT) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) next_state = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (tmr_hit_c) begin
            next_state   = ST_RESYNC;
            timeout_fire = 1'b1;
          end else if (DEC_SYNC_START || DEC_CONFIG_EN) begin
            next_state = ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (tmr_hit_c) begin
            next_state   = ST_RESYNC;
            timeout_fire = 1'b1;
          end else if (CFG_DONE) begin
            next_state = ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: begin
          if (tmr_hit_c) begin
            next_state   = ST_RESYNC;
            timeout_fire = 1'b1;
          end else if (DEC_FRAME_START) begin
            next_state = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (tmr_hit_c) begin
            next_state   = ST_RESYNC;
            timeout_fire = 1'b1;
          end else if (DEC_ERROR || DES_RSYNC) begin
            next_state = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (tmr_hit_c) begin
            next_state = (retry == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_WAIT_SYNC;
          end
        end
        ST_FAIL: begin
          if (START) next_state = ST_WAIT_SYNC;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Event decode shared by counters and outputs.
  assign start_ok     = ((state == ST_IDLE) || (state == ST_FAIL)) && (next_state == ST_WAIT_SYNC);
  assign resync_entry = (state != ST_RESYNC) && (next_state == ST_RESYNC);
  assign frame_inc    = ((state == ST_WAIT_FRAME) && (next_state == ST_STREAM)) ||
                        ((state == ST_STREAM) && (next_state == ST_STREAM) && DEC_FRAME_START);

  // Output decode from the upcoming state so registered outputs line up with STATE.
  always_comb begin
    nxt_dec_enable = dec_enabled(next_state);
    nxt_cfg_start  = (next_state == ST_CONFIG) && (state != ST_CONFIG);
    nxt_cfg_done   = (state == ST_CONFIG) && (next_state == ST_WAIT_FRAME);
    nxt_rsync      = (next_state == ST_RESYNC);
    nxt_link_up    = (next_state == ST_STREAM);
    nxt_link_fail  = (next_state == ST_FAIL);
  end

  // Output registers.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      DEC_ENABLE      <= 1'b0;
      DEC_CONFIG_DONE <= 1'b0;
      DEC_RSYNC       <= 1'b0;
      CFG_START       <= 1'b0;
      LINK_UP         <= 1'b0;
      LINK_FAIL       <= 1'b0;
      TIMEOUT_EV      <= 1'b0;
    end else begin
      DEC_ENABLE      <= nxt_dec_enable;
      DEC_CONFIG_DONE <= nxt_cfg_done;
      DEC_RSYNC       <= nxt_rsync;
      CFG_START       <= nxt_cfg_start;
      LINK_UP         <= nxt_link_up;
      LINK_FAIL       <= nxt_link_fail;
      TIMEOUT_EV      <= timeout_fire;
    end
  end

  // Retry, frame and error counters.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      retry     <= '0;
      FRAME_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      if (ABORT || start_ok || ((state == ST_WAIT_FRAME) && (next_state == ST_STREAM))) begin
        retry <= '0;
      end else if (resync_entry) begin
        retry <= retry + RETRY_W'(1);
      end
      if (start_ok) begin
        FRAME_CNT <= '0;
      end else if (frame_inc) begin
        FRAME_CNT <= FRAME_CNT + FCNT_W'(1);
      end
      if (resync_entry && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_naneye_link_sequencer.sv
// Directed bench for the NanEye link sequencer with short timeouts.
module tb_naneye_link_sequencer;

  logic        SCLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        DEC_SYNC_START = 1'b0;
  logic        DEC_CONFIG_EN = 1'b0;
  logic        DEC_FRAME_START = 1'b0;
  logic        DEC_ERROR = 1'b0;
  logic        DES_RSYNC = 1'b0;
  logic        CFG_DONE = 1'b0;
  logic        DEC_ENABLE;
  logic        DEC_CONFIG_DONE;
  logic        DEC_RSYNC;
  logic        CFG_START;
  logic        LINK_UP;
  logic        LINK_FAIL;
  logic        TIMEOUT_EV;
  logic [15:0] FRAME_CNT;
  logic [7:0]  ERR_CNT;
  logic [2:0]  STATE;

  int vectors = 0;
  int miscompares = 0;

  naneye_link_sequencer #(
    .SYNC_TIMEOUT  (16),
    .FRAME_TIMEOUT (32),
    .MAX_RETRY     (3),
    .RSYNC_LEN     (4),
    .TMR_W         (24),
    .FCNT_W        (16)
  ) dut (
    .SCLOCK          (SCLOCK),
    .RESET           (RESET),
    .START           (START),
    .ABORT           (ABORT),
    .DEC_SYNC_START  (DEC_SYNC_START),
    .DEC_CONFIG_EN   (DEC_CONFIG_EN),
    .DEC_FRAME_START (DEC_FRAME_START),
    .DEC_ERROR       (DEC_ERROR),
    .DES_RSYNC       (DES_RSYNC),
    .CFG_DONE        (CFG_DONE),
    .DEC_ENABLE      (DEC_ENABLE),
    .DEC_CONFIG_DONE (DEC_CONFIG_DONE),
    .DEC_RSYNC       (DEC_RSYNC),
    .CFG_START       (CFG_START),
    .LINK_UP         (LINK_UP),
    .LINK_FAIL       (LINK_FAIL),
    .TIMEOUT_EV      (TIMEOUT_EV),
    .FRAME_CNT       (FRAME_CNT),
    .ERR_CNT         (ERR_CNT),
    .STATE           (STATE)
  );

  always #5 SCLOCK = ~SCLOCK;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge SCLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive sync, config done and first frame on consecutive edges.
  task automatic fast_bringup();
    DEC_SYNC_START = 1'b1; step(1); DEC_SYNC_START = 1'b0;
    CFG_DONE = 1'b1;       step(1); CFG_DONE = 1'b0;
    DEC_FRAME_START = 1'b1; step(1); DEC_FRAME_START = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_state", 32'(STATE), 0);
    check("rst_enable", 32'(DEC_ENABLE), 0);
    check("rst_rsync", 32'(DEC_RSYNC), 0);
    check("rst_fcnt", 32'(FRAME_CNT), 0);
    check("rst_ecnt", 32'(ERR_CNT), 0);
    RESET = 1'b1;
    step(1);

    // Happy path
    START = 1'b1; step(1); START = 1'b0;
    check("hp_ws_state", 32'(STATE), 1);
    check("hp_ws_enable", 32'(DEC_ENABLE), 1);
    step(4);
    DEC_SYNC_START = 1'b1; step(1); DEC_SYNC_START = 1'b0;
    check("hp_cfg_state", 32'(STATE), 2);
    check("hp_cfg_start", 32'(CFG_START), 1);
    step(1);
    check("hp_cfg_start_drop", 32'(CFG_START), 0);
    step(8);
    CFG_DONE = 1'b1; step(1); CFG_DONE = 1'b0;
    check("hp_wf_state", 32'(STATE), 3);
    check("hp_cfg_done", 32'(DEC_CONFIG_DONE), 1);
    step(1);
    check("hp_cfg_done_drop", 32'(DEC_CONFIG_DONE), 0);
    step(2);
    DEC_FRAME_START = 1'b1; step(1); DEC_FRAME_START = 1'b0;
    check("hp_link_up", 32'(LINK_UP), 1);
    check("hp_fcnt", 32'(FRAME_CNT), 1);
    check("hp_stream_state", 32'(STATE), 4);

    // Streaming: nine more frames 20 cycles apart
    for (int i = 0; i < 9; i++) begin
      step(19);
      DEC_FRAME_START = 1'b1; step(1); DEC_FRAME_START = 1'b0;
    end
    check("st_fcnt10", 32'(FRAME_CNT), 10);
    check("st_no_err", 32'(ERR_CNT), 0);
    check("st_no_rsync", 32'(DEC_RSYNC), 0);
    step(5);
    START = 1'b1; step(1); START = 1'b0;
    check("st_start_ignored", 32'(STATE), 4);
    check("st_start_fcnt", 32'(FRAME_CNT), 10);
    step(25);
    check("st_pre_timeout", 32'(STATE), 4);
    step(1);
    check("st_to_state", 32'(STATE), 5);
    check("st_to_ev", 32'(TIMEOUT_EV), 1);
    check("st_to_rsync", 32'(DEC_RSYNC), 1);
    check("st_to_ecnt", 32'(ERR_CNT), 1);
    check("st_to_linkup", 32'(LINK_UP), 0);
    step(3);
    check("rs_hold", 32'(DEC_RSYNC), 1);
    check("rs_ev_drop", 32'(TIMEOUT_EV), 0);
    step(1);
    check("rs_release", 32'(DEC_RSYNC), 0);
    check("rs_back_ws", 32'(STATE), 1);

    // Recovery, then same-cycle error and frame
    fast_bringup();
    check("rc_state", 32'(STATE), 4);
    check("rc_fcnt", 32'(FRAME_CNT), 11);
    step(3);
    DEC_ERROR = 1'b1; DEC_FRAME_START = 1'b1; step(1);
    DEC_ERROR = 1'b0; DEC_FRAME_START = 1'b0;
    check("ef_state", 32'(STATE), 5);
    check("ef_fcnt", 32'(FRAME_CNT), 11);
    check("ef_ecnt", 32'(ERR_CNT), 2);
    check("ef_no_timeout", 32'(TIMEOUT_EV), 0);
    step(4);
    check("ef_ws", 32'(STATE), 1);
    step(16);
    check("ef_rs2", 32'(STATE), 5);
    check("ef_ecnt3", 32'(ERR_CNT), 3);
    step(4);
    check("ef_retry_reset", 32'(STATE), 1);
    step(16);
    check("ef_rs3", 32'(STATE), 5);
    step(4);
    check("ef_fail_state", 32'(STATE), 6);
    check("ef_link_fail", 32'(LINK_FAIL), 1);
    check("ef_fail_enable", 32'(DEC_ENABLE), 0);

    // Restart from FAIL, then async reset while streaming
    START = 1'b1; step(1); START = 1'b0;
    check("fr_state", 32'(STATE), 1);
    check("fr_fcnt", 32'(FRAME_CNT), 0);
    check("fr_link_fail", 32'(LINK_FAIL), 0);
    fast_bringup();
    check("ar_pre_linkup", 32'(LINK_UP), 1);
    check("ar_pre_fcnt", 32'(FRAME_CNT), 1);
    #3 RESET = 1'b0;
    #1;
    check("ar_linkup", 32'(LINK_UP), 0);
    check("ar_enable", 32'(DEC_ENABLE), 0);
    check("ar_fcnt", 32'(FRAME_CNT), 0);
    check("ar_ecnt", 32'(ERR_CNT), 0);
    check("ar_state", 32'(STATE), 0);
    #2 RESET = 1'b1;
    step(1);

    // No sync: three timed-out attempts end in FAIL
    START = 1'b1; step(1); START = 1'b0;
    step(15);
    check("ns_pre_timeout", 32'(STATE), 1);
    check("ns_pre_ev", 32'(TIMEOUT_EV), 0);
    step(1);
    check("ns_ev", 32'(TIMEOUT_EV), 1);
    check("ns_rsync", 32'(DEC_RSYNC), 1);
    check("ns_ecnt1", 32'(ERR_CNT), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ns_rsync_hold", 32'(DEC_RSYNC), 1);
    end
    step(1);
    check("ns_rsync_len", 32'(DEC_RSYNC), 0);
    step(39);
    check("ns_last_rs", 32'(STATE), 5);
    step(1);
    check("ns_fail", 32'(LINK_FAIL), 1);
    check("ns_ecnt3", 32'(ERR_CNT), 3);

    // Abort in the second RESYNC cycle
    START = 1'b1; step(1); START = 1'b0;
    step(16);
    check("ab_rs", 32'(STATE), 5);
    step(1);
    check("ab_rs_c2", 32'(DEC_RSYNC), 1);
    ABORT = 1'b1; step(1); ABORT = 1'b0;
    check("ab_idle", 32'(STATE), 0);
    check("ab_rsync", 32'(DEC_RSYNC), 0);
    check("ab_enable", 32'(DEC_ENABLE), 0);
    check("ab_ecnt_kept", 32'(ERR_CNT), 4);
    START = 1'b1; step(1); START = 1'b0;
    check("ab_restart", 32'(STATE), 1);
    step(20);
    check("ab_retry_clear", 32'(STATE), 1);
    check("ab_ecnt5", 32'(ERR_CNT), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
